adder_result_fifo: RTL and testbench

- Downstream stage of the adder IP. Captures every valid adder result (sum, cout, ovf) into a synchronous FIFO.
- Drains the FIFO to a consumer over a valid/ready handshake.
- The adder output has no backpressure, so this block absorbs bursts, drops results on overflow and counts the drops.
- Sits between the adder's result port and the checker/consumer logic.

---
 rtl/adder_result_fifo.sv | 133 +++++++++++++
 tb/tb_adder_result_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// adder_result_fifo
// Captures every valid adder result {ovf, cout, sum} into a show-ahead
// synchronous FIFO and drains it to a consumer over valid/ready.
// The adder cannot be stalled, so a result arriving while the FIFO is full
// and not being popped is discarded and counted in a saturating drop counter.
// Optional build macro ADDER_RES_OVF_STATS_EN adds ovf_cnt, a saturating
// count of accepted results that carried the signed-overflow flag.
module adder_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_sum,
  input  logic                         in_cout,
  input  logic                         in_ovf,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_sum,
  output logic                         out_cout,
  output logic                         out_ovf,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic [CNT_W-1:0]             drop_cnt,
  input  logic                         clr_cnt
`ifdef ADDER_RES_OVF_STATS_EN
  ,
  output logic [CNT_W-1:0]             ovf_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = DATA_WIDTH + 2;

  // Counter increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          drop;

  // Occupancy flags come from the registered level, never from pointer equality.
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign out_valid = !empty;

  // A full FIFO can still accept a result when the head leaves in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Show-ahead head entry; outputs are forced to zero while nothing is stored.
  assign head     = mem[rd_ptr];
  assign out_sum  = empty ? '0   : head[DATA_WIDTH-1:0];
  assign out_cout = empty ? 1'b0 : head[DATA_WIDTH];
  assign out_ovf  = empty ? 1'b0 : head[DATA_WIDTH+1];

  // Storage array: written on push, never reset (contents behind rd_ptr are dead).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_ovf, in_cout, in_sum};
    end
  end

  // Write pointer advances on every accepted result, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // Read pointer advances when the consumer takes the head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Occupancy: simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Drop statistics; a clear in the same cycle as a drop takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (clr_cnt) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

`ifdef ADDER_RES_OVF_STATS_EN
  // Overflow statistics count only results that actually entered the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= '0;
    end else if (push && in_ovf) begin
      ovf_cnt <= sat_inc(ovf_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Scoreboard bench for adder_result_fifo. Counters are built 4 bits wide so
// saturation is reachable in a short run.
module tb_adder_result_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_sum;
  logic          in_cout;
  logic          in_ovf;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic [CW-1:0] drop_cnt;
  logic          clr_cnt;
`ifdef ADDER_RES_OVF_STATS_EN
  logic [CW-1:0] ovf_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_drop   = 0;
  int m_ovf    = 0;
  logic [DW+1:0] sb [$];

  adder_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .level(level), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .clr_cnt(clr_cnt)
`ifdef ADDER_RES_OVF_STATS_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check state against the model at negedge, drive inputs,
  // score a pop against the queue head, update the model, cross the edge.
  task automatic step(input logic v, input logic [DW-1:0] s, input logic c,
                      input logic o, input logic rdy, input logic clr);
    int sz;
    logic mpop, mpush;
    logic [DW+1:0] e;
    @(negedge clk);
    sz = sb.size();
    chk("level", 64'(level), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sz != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`ifdef ADDER_RES_OVF_STATS_EN
    chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
`endif
    if (sz == 0) begin
      chk("idle_out", 64'({out_ovf, out_cout, out_sum}), 64'(0));
    end
    in_valid = v; in_sum = s; in_cout = c; in_ovf = o;
    out_ready = rdy; clr_cnt = clr;
    mpop  = (sz != 0) && rdy;
    mpush = v && ((sz < DEPTH) || mpop);
    if (mpop) begin
      e = sb.pop_front();
      chk("out_sum", 64'(out_sum), 64'(e[DW-1:0]));
      chk("out_cout", 64'(out_cout), 64'(e[DW]));
      chk("out_ovf", 64'(out_ovf), 64'(e[DW+1]));
    end
    if (mpush) sb.push_back({o, c, s});
    if (clr) m_drop = 0;
    else if (v && !mpush && m_drop < MAXC) m_drop++;
    if (clr) m_ovf = 0;
    else if (mpush && o && m_ovf < MAXC) m_ovf++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; in_ovf = 1'b0;
    out_ready = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_out", 64'({out_ovf, out_cout, out_sum}), 64'(0));
    rst_n = 1'b1;

    // Single push, visible after one edge, then popped.
    step(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_valid", 64'(out_valid), 64'(1));
    chk("single_sum", 64'(out_sum), 64'h5);
    chk("single_level", 64'(level), 64'(1));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("single_empty", 64'(empty), 64'(1));

    // Fill with 1..8, overflow with 9, then full push+pop of 0xAAAAAAAA.
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), i[0], i[1], 1'b0, 1'b0);
    chk("fill_full", 64'(full), 64'(1));
    step(1'b1, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovfl_drop", 64'(drop_cnt), 64'(1));
    chk("ovfl_level", 64'(level), 64'(8));
    step(1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pp_drop", 64'(drop_cnt), 64'(1));
    chk("pp_level", 64'(level), 64'(8));
    repeat (8) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Wrap-around with interleaved push/pop.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      chk("wrap_level", 64'(level <= 1), 64'(1));
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("wrap_drop", 64'(drop_cnt), 64'(1));

    // Backpressure hold.
    step(1'b1, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_sum", 64'(out_sum), 64'h1234);
      chk("hold_valid", 64'(out_valid), 64'(1));
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Statistics: clear, then overflow-flagged pushes with one dropped.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, DW'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, DW'(200 + i), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stat_drop", 64'(drop_cnt), 64'(1));
`ifdef ADDER_RES_OVF_STATS_EN
    chk("stat_ovf", 64'(ovf_cnt), 64'(2));
`endif
    step(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_drop", 64'(drop_cnt), 64'(0));
    chk("clr_level", 64'(level), 64'(8));
`ifdef ADDER_RES_OVF_STATS_EN
    chk("clr_ovf", 64'(ovf_cnt), 64'(0));
`endif

    // Drop counter saturation.
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("drop_sat", 64'(drop_cnt), 64'(MAXC));

    // Drain to level 5, then reset mid-operation.
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_level", 64'(level), 64'(5));
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_sum = 32'h77; out_ready = 1'b0;
    #1;
    chk("mid_rst_empty", 64'(empty), 64'(1));
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_drop", 64'(drop_cnt), 64'(0));
    chk("mid_rst_level", 64'(level), 64'(0));
    sb.delete(); m_drop = 0; m_ovf = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle();
    step(1'b1, 32'h42, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
